meta_write_scheduler: RTL and testbench

META_WRITE_SCHEDULER -- requirements
Module: meta_write_scheduler

---
 rtl/meta_write_scheduler.sv | 161 ++++++++++++++++
 tb/tb_meta_write_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_write_scheduler.sv
// meta_write_scheduler
//   Serialises writes into a metadata array. After reset the block sweeps
//   every set (idx 0..NSETS-1) with an invalid entry (way_en=1, tag=0,
//   coh_state=0). Once the sweep is done it arbitrates three requesters.
//   Requester 0 has strict priority. Requesters 1 and 2 share by round-robin.
//   The winner goes into a single output register, so the latency is one
//   cycle. With io_out_ready held high the block sustains one write per cycle.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   io_in_<n>_*  (n=0..2) : requester valid/ready handshake plus payload
//                           (idx, way_en, data_tag, data_coh_state)
//   io_out_*              : registered write toward the array (valid/ready)
//   io_chosen             : source of the held entry (0..2 requester, 3 sweep)
//   io_init_done          : high once the last sweep write has left the register
module meta_write_scheduler #(
    parameter int NSETS = 128,
    parameter int IDX_W = 7,
    parameter int TAG_W = 19
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             io_in_0_valid,
    output logic             io_in_0_ready,
    input  logic [IDX_W-1:0] io_in_0_bits_idx,
    input  logic             io_in_0_bits_way_en,
    input  logic [TAG_W-1:0] io_in_0_bits_data_tag,
    input  logic [1:0]       io_in_0_bits_data_coh_state,

    input  logic             io_in_1_valid,
    output logic             io_in_1_ready,
    input  logic [IDX_W-1:0] io_in_1_bits_idx,
    input  logic             io_in_1_bits_way_en,
    input  logic [TAG_W-1:0] io_in_1_bits_data_tag,
    input  logic [1:0]       io_in_1_bits_data_coh_state,

    input  logic             io_in_2_valid,
    output logic             io_in_2_ready,
    input  logic [IDX_W-1:0] io_in_2_bits_idx,
    input  logic             io_in_2_bits_way_en,
    input  logic [TAG_W-1:0] io_in_2_bits_data_tag,
    input  logic [1:0]       io_in_2_bits_data_coh_state,

    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic [IDX_W-1:0] io_out_bits_idx,
    output logic             io_out_bits_way_en,
    output logic [TAG_W-1:0] io_out_bits_data_tag,
    output logic [1:0]       io_out_bits_data_coh_state,
    output logic [1:0]       io_chosen,
    output logic             io_init_done
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             way_en;
        logic [TAG_W-1:0] tag;
        logic [1:0]       coh;
    } entry_t;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    entry_t           out_q, out_d;
    logic [1:0]       chosen_q, chosen_d;
    logic             ptr_q, ptr_d;      // 0: favour requester 1, 1: favour requester 2
    logic             done_q, done_d;

    logic             slot_free;
    logic [2:0]       req_vld;
    entry_t           req_bits [3];
    logic [2:0]       grant;

    assign req_vld     = {io_in_2_valid, io_in_1_valid, io_in_0_valid};
    assign req_bits[0] = '{idx: io_in_0_bits_idx, way_en: io_in_0_bits_way_en,
                           tag: io_in_0_bits_data_tag, coh: io_in_0_bits_data_coh_state};
    assign req_bits[1] = '{idx: io_in_1_bits_idx, way_en: io_in_1_bits_way_en,
                           tag: io_in_1_bits_data_tag, coh: io_in_1_bits_data_coh_state};
    assign req_bits[2] = '{idx: io_in_2_bits_idx, way_en: io_in_2_bits_way_en,
                           tag: io_in_2_bits_data_tag, coh: io_in_2_bits_data_coh_state};

    // The register can take a new entry when it is empty or is draining this cycle.
    assign slot_free = ~out_valid_q | io_out_ready;

    // Requester 0 wins outright. Between 1 and 2 the pointer only breaks a tie.
    assign grant[0] = req_vld[0];
    assign grant[1] = ~req_vld[0] & req_vld[1] & (~req_vld[2] | ~ptr_q);
    assign grant[2] = ~req_vld[0] & req_vld[2] & (~req_vld[1] |  ptr_q);

    assign io_in_0_ready = grant[0] & slot_free & (state_q == ST_RUN);
    assign io_in_1_ready = grant[1] & slot_free & (state_q == ST_RUN);
    assign io_in_2_ready = grant[2] & slot_free & (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        chosen_d    = chosen_q;
        ptr_d       = ptr_q;
        if (slot_free) begin
            out_valid_d = 1'b0;
            if (state_q == ST_INIT) begin
                out_valid_d = 1'b1;
                out_d       = '{idx: cnt_q, way_en: 1'b1, tag: '0, coh: 2'd0};
                chosen_d    = 2'd3;
                // The counter parks on the last set. Leaving INIT stops any re-sweep.
                if (cnt_q == IDX_W'(NSETS - 1)) state_d = ST_RUN;
                else                            cnt_d   = cnt_q + IDX_W'(1);
            end else if (grant[0]) begin
                out_valid_d = 1'b1;
                out_d       = req_bits[0];
                chosen_d    = 2'd0;
            end else if (grant[1]) begin
                out_valid_d = 1'b1;
                out_d       = req_bits[1];
                chosen_d    = 2'd1;
                ptr_d       = 1'b1;
            end else if (grant[2]) begin
                out_valid_d = 1'b1;
                out_d       = req_bits[2];
                chosen_d    = 2'd2;
                ptr_d       = 1'b0;
            end
        end
        // Done means the block is in RUN and the register no longer holds a sweep write.
        done_d = done_q | ((state_d == ST_RUN) & ~(out_valid_d & (chosen_d == 2'd3)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            chosen_q    <= 2'd0;
            ptr_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            chosen_q    <= chosen_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
        end
    end

    assign io_out_valid               = out_valid_q;
    assign io_out_bits_idx            = out_q.idx;
    assign io_out_bits_way_en         = out_q.way_en;
    assign io_out_bits_data_tag       = out_q.tag;
    assign io_out_bits_data_coh_state = out_q.coh;
    assign io_chosen                  = chosen_q;
    assign io_init_done               = done_q;

endmodule

// File: tb/tb_meta_write_scheduler.sv
module tb_meta_write_scheduler;
    localparam int NSETS = 128;
    localparam int IDX_W = 7;
    localparam int TAG_W = 19;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       in_v;
    logic [2:0]       in_rdy;
    logic [IDX_W-1:0] in_idx [3];
    logic             in_way [3];
    logic [TAG_W-1:0] in_tag [3];
    logic [1:0]       in_coh [3];
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_way;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_coh;
    logic [1:0]       chosen;
    logic             init_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: holds what the spec says the output register contains.
    bit               m_init = 1'b1;
    int               m_cnt  = 0;
    bit               m_vld  = 1'b0;
    logic [IDX_W-1:0] m_idx  = '0;
    logic             m_way  = 1'b0;
    logic [TAG_W-1:0] m_tag  = '0;
    logic [1:0]       m_coh  = '0;
    logic [1:0]       m_chosen = '0;
    bit               m_ptr  = 1'b0;   // 0: requester 1 next, 1: requester 2 next
    bit               m_done = 1'b0;

    meta_write_scheduler #(.NSETS(NSETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .io_in_0_valid(in_v[0]), .io_in_0_ready(in_rdy[0]), .io_in_0_bits_idx(in_idx[0]),
        .io_in_0_bits_way_en(in_way[0]), .io_in_0_bits_data_tag(in_tag[0]),
        .io_in_0_bits_data_coh_state(in_coh[0]),
        .io_in_1_valid(in_v[1]), .io_in_1_ready(in_rdy[1]), .io_in_1_bits_idx(in_idx[1]),
        .io_in_1_bits_way_en(in_way[1]), .io_in_1_bits_data_tag(in_tag[1]),
        .io_in_1_bits_data_coh_state(in_coh[1]),
        .io_in_2_valid(in_v[2]), .io_in_2_ready(in_rdy[2]), .io_in_2_bits_idx(in_idx[2]),
        .io_in_2_bits_way_en(in_way[2]), .io_in_2_bits_data_tag(in_tag[2]),
        .io_in_2_bits_data_coh_state(in_coh[2]),
        .io_out_ready(out_ready), .io_out_valid(out_valid), .io_out_bits_idx(out_idx),
        .io_out_bits_way_en(out_way), .io_out_bits_data_tag(out_tag),
        .io_out_bits_data_coh_state(out_coh), .io_chosen(chosen), .io_init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Which requester the spec says wins this cycle, or -1 when nobody does.
    function automatic int m_winner();
        if (m_init || (m_vld && !out_ready)) return -1;
        if (in_v[0]) return 0;
        if (in_v[1] && in_v[2]) return m_ptr ? 2 : 1;
        if (in_v[1]) return 1;
        if (in_v[2]) return 2;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        bit free;
        w    = m_winner();
        free = !m_vld || out_ready;
        if (reset) begin
            m_init = 1; m_cnt = 0; m_vld = 0; m_idx = '0; m_way = 0; m_tag = '0;
            m_coh = '0; m_chosen = '0; m_ptr = 0; m_done = 0;
        end else begin
            if (m_init) begin
                if (free) begin
                    m_vld = 1; m_idx = IDX_W'(m_cnt); m_way = 1; m_tag = '0; m_coh = '0;
                    m_chosen = 2'd3;
                    if (m_cnt == NSETS - 1) m_init = 0;
                    else                    m_cnt++;
                end
            end else if (w >= 0) begin
                m_vld = 1; m_idx = in_idx[w]; m_way = in_way[w]; m_tag = in_tag[w];
                m_coh = in_coh[w]; m_chosen = 2'(w);
                if (w == 1) m_ptr = 1;
                else if (w == 2) m_ptr = 0;
            end else if (free) begin
                m_vld = 0;
            end
            m_done = m_done || (!m_init && !(m_vld && m_chosen == 2'd3));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_payload();
        for (int n = 0; n < 3; n++) begin
            in_idx[n] = IDX_W'($urandom);
            in_way[n] = 1'($urandom);
            in_tag[n] = TAG_W'($urandom);
            in_coh[n] = 2'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1; in_v = 3'b111; out_ready = 1; rand_payload();
        tick(); tick();
        checks++;
        if ({out_valid, chosen, out_idx, out_way, out_tag, out_coh} !== '0) begin
            failures++;
            $display("FAIL reset_out: got v=%0b ch=%0d idx=%0d way=%0b tag=%h coh=%0d, want all 0",
                     out_valid, chosen, out_idx, out_way, out_tag, out_coh);
        end
        checks++;
        if (init_done !== 1'b0) begin
            failures++; $display("FAIL reset_init_done: got %0b want 0", init_done);
        end
        checks++;
        if (in_rdy !== 3'b000) begin
            failures++; $display("FAIL reset_ready: got %b want 000", in_rdy);
        end
    endtask

    task automatic test_sweep();
        reset = 0; in_v = 3'b111; out_ready = 1;
        #1;
        checks++;
        if (in_rdy !== 3'b000) begin
            failures++; $display("FAIL sweep_ready_start: got %b want 000", in_rdy);
        end
        for (int k = 0; k < NSETS; k++) begin
            rand_payload();
            tick();
            checks++;
            if ({out_valid, out_idx, out_way, out_tag, out_coh, chosen, init_done} !==
                {1'b1, IDX_W'(k), 1'b1, TAG_W'(0), 2'd0, 2'd3, 1'b0}) begin
                failures++;
                $display("FAIL sweep_entry k=%0d: got v=%0b idx=%0d way=%0b tag=%h coh=%0d ch=%0d done=%0b",
                         k, out_valid, out_idx, out_way, out_tag, out_coh, chosen, init_done);
            end
            if (k < NSETS - 1) begin
                checks++;
                if (in_rdy !== 3'b000) begin
                    failures++; $display("FAIL sweep_ready k=%0d: got %b want 000", k, in_rdy);
                end
            end
        end
        in_v = 3'b000;
        tick();
        checks++;
        if ({init_done, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL sweep_done: got done=%0b valid=%0b want done=1 valid=0", init_done, out_valid);
        end
    endtask

    task automatic test_sweep_stall();
        int e = 0;
        int cyc = 0;
        logic [IDX_W-1:0] held;
        reset = 1; in_v = 3'b000; out_ready = 1;
        tick();
        reset = 0;
        while (e < NSETS && cyc < 1000) begin
            out_ready = cyc[0];
            #1;
            if (out_valid) begin
                held = IDX_W'(e);
                checks++;
                if ({out_idx, chosen, init_done} !== {held, 2'd3, 1'b0}) begin
                    failures++;
                    $display("FAIL stall_sweep_entry: got idx=%0d ch=%0d done=%0b want idx=%0d ch=3 done=0",
                             out_idx, chosen, init_done, e);
                end
                if (out_ready) e++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (e !== NSETS) begin
            failures++; $display("FAIL stall_sweep_count: got %0d transfers want %0d", e, NSETS);
        end
        out_ready = 1;
        #1;
        checks++;
        if ({init_done, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall_sweep_done: got done=%0b valid=%0b want done=1 valid=0", init_done, out_valid);
        end
    endtask

    task automatic test_priority();
        int exp_src;
        logic [TAG_W-1:0] t;
        out_ready = 1; in_v = 3'b111;
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            #1;
            checks++;
            if (in_rdy !== 3'b001) begin
                failures++; $display("FAIL prio_ready i=%0d: got %b want 001", i, in_rdy);
            end
            t = in_tag[0];
            tick();
            checks++;
            if ({out_valid, chosen, out_tag} !== {1'b1, 2'd0, t}) begin
                failures++;
                $display("FAIL prio_out i=%0d: got v=%0b ch=%0d tag=%h want v=1 ch=0 tag=%h",
                         i, out_valid, chosen, out_tag, t);
            end
        end
        in_v = 3'b110;
        for (int i = 0; i < 4; i++) begin
            exp_src = (i % 2 == 0) ? 1 : 2;
            rand_payload();
            #1;
            checks++;
            if (in_rdy !== 3'(1 << exp_src)) begin
                failures++;
                $display("FAIL rr_ready i=%0d: got %b want %b", i, in_rdy, 3'(1 << exp_src));
            end
            t = in_tag[exp_src];
            tick();
            checks++;
            if ({out_valid, chosen, out_tag} !== {1'b1, 2'(exp_src), t}) begin
                failures++;
                $display("FAIL rr_out i=%0d: got v=%0b ch=%0d tag=%h want v=1 ch=%0d tag=%h",
                         i, out_valid, chosen, out_tag, exp_src, t);
            end
        end
        in_v = 3'b000;
        tick();
    endtask

    task automatic test_stall_hold();
        out_ready = 1; in_v = 3'b010; rand_payload(); in_tag[1] = 19'h12345;
        #1;
        checks++;
        if (in_rdy !== 3'b010) begin
            failures++; $display("FAIL hold_accept: got %b want 010", in_rdy);
        end
        tick();
        out_ready = 0; in_v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            #1;
            checks++;
            if ({out_valid, chosen, out_tag, in_rdy} !== {1'b1, 2'd1, 19'h12345, 3'b000}) begin
                failures++;
                $display("FAIL hold_stall i=%0d: got v=%0b ch=%0d tag=%h rdy=%b want v=1 ch=1 tag=12345 rdy=000",
                         i, out_valid, chosen, out_tag, in_rdy);
            end
            tick();
        end
        out_ready = 1; in_v = 3'b010;
        #1;
        checks++;
        if (in_rdy !== 3'b010) begin
            failures++; $display("FAIL hold_release: got %b want 010", in_rdy);
        end
        in_v = 3'b000;
        tick();
    endtask

    task automatic test_ptr_after_p0();
        logic [2:0] exp_rdy [4];
        exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b001; exp_rdy[2] = 3'b010; exp_rdy[3] = 3'b100;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_v = (i == 0) ? 3'b100 : (i == 1) ? 3'b111 : 3'b110;
            rand_payload();
            #1;
            checks++;
            if (in_rdy !== exp_rdy[i]) begin
                failures++; $display("FAIL ptr_p0 step=%0d: got %b want %b", i, in_rdy, exp_rdy[i]);
            end
            tick();
        end
        in_v = 3'b000;
        tick();
    endtask

    task automatic test_reset_midsweep();
        reset = 1; in_v = 3'b000; out_ready = 1;
        tick();
        reset = 0;
        for (int k = 0; k <= 60; k++) tick();
        checks++;
        if ({out_valid, out_idx} !== {1'b1, IDX_W'(60)}) begin
            failures++; $display("FAIL midsweep_at60: got v=%0b idx=%0d want v=1 idx=60", out_valid, out_idx);
        end
        reset = 1;
        tick();
        checks++;
        if ({out_valid, init_done} !== 2'b00) begin
            failures++;
            $display("FAIL midsweep_reset: got v=%0b done=%0b want 0 0", out_valid, init_done);
        end
        reset = 0;
        tick();
        checks++;
        if ({out_valid, out_idx, chosen, init_done} !== {1'b1, IDX_W'(0), 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL midsweep_restart: got v=%0b idx=%0d ch=%0d done=%0b want v=1 idx=0 ch=3 done=0",
                     out_valid, out_idx, chosen, init_done);
        end
    endtask

    task automatic test_random();
        int w;
        logic [2:0] exp_rdy;
        reset = 1; in_v = 3'b000; out_ready = 1;
        tick();
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom % 400) == 0;
            in_v      = 3'($urandom);
            out_ready = ($urandom % 4) != 0;
            rand_payload();
            #1;
            w = m_winner();
            exp_rdy = 3'b000;
            if (w >= 0) exp_rdy[w] = 1'b1;
            checks++;
            if (in_rdy !== exp_rdy) begin
                failures++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_rdy, exp_rdy);
            end
            checks++;
            if ({out_valid, init_done} !== {m_vld, m_done}) begin
                failures++;
                $display("FAIL rand_status c=%0d: got v=%0b done=%0b want v=%0b done=%0b",
                         c, out_valid, init_done, m_vld, m_done);
            end
            if (m_vld) begin
                checks++;
                if ({out_idx, out_way, out_tag, out_coh, chosen} !== {m_idx, m_way, m_tag, m_coh, m_chosen}) begin
                    failures++;
                    $display("FAIL rand_payload c=%0d: got idx=%0d way=%0b tag=%h coh=%0d ch=%0d want idx=%0d way=%0b tag=%h coh=%0d ch=%0d",
                             c, out_idx, out_way, out_tag, out_coh, chosen, m_idx, m_way, m_tag, m_coh, m_chosen);
                end
            end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; in_v = 3'b000; out_ready = 1; rand_payload();
        test_reset();
        test_sweep();
        test_sweep_stall();
        test_priority();
        test_stall_hold();
        test_ptr_after_p0();
        test_reset_midsweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
